// File: rtl/dir_read_rsp_route_pkg.sv
// Shared directory types for the directory request/response path.
//   hpdcache_dir_addr_t   : directory set address
//   hpdcache_way_vector_t : one bit per way
//   hpdcache_dir_entry_t  : one directory entry
//   dir_src_e             : requester that issued a directory access
//   dir_tag_t             : per-read tracking tag travelling alongside the SRAM read
//   dir_core_rsp_t        : payload stored in the core response FIFO
package dir_read_rsp_route_pkg;

    localparam int unsigned NUM_WAYS    = 4;
    localparam int unsigned DIR_ADDR_W  = 8;
    localparam int unsigned DIR_ENTRY_W = 16;

    typedef logic [DIR_ADDR_W-1:0]  hpdcache_dir_addr_t;
    typedef logic [NUM_WAYS-1:0]    hpdcache_way_vector_t;
    typedef logic [DIR_ENTRY_W-1:0] hpdcache_dir_entry_t;
    typedef hpdcache_dir_entry_t [NUM_WAYS-1:0] dir_entries_t;

    typedef enum logic {
        DIR_SRC_CORE = 1'b0,
        DIR_SRC_COH  = 1'b1
    } dir_src_e;

    typedef struct packed {
        logic                 valid;
        dir_src_e             src;
        hpdcache_dir_addr_t   addr;
        hpdcache_way_vector_t cs;
    } dir_tag_t;

    typedef struct packed {
        hpdcache_dir_addr_t   addr;
        hpdcache_way_vector_t cs;
        dir_entries_t         entry;
    } dir_core_rsp_t;

    // Ways that were not selected return garbage from the SRAM; zero them.
    function automatic dir_entries_t mask_entries(input dir_entries_t ent,
                                                  input hpdcache_way_vector_t cs);
        dir_entries_t res;
        for (int w = 0; w < NUM_WAYS; w++) begin
            res[w] = cs[w] ? ent[w] : '0;
        end
        return res;
    endfunction

endpackage

// File: rtl/fifo_v3.sv
// Synchronous FIFO.
//   clk_i/rst_ni : clock, async active-low reset
//   flush_i      : drop all contents
//   full_o/empty_o/usage_o : status; usage_o wraps to 0 when full (use full_o)
//   data_i/push_i, data_o/pop_i : write and read ports
// A push while full is accepted when a pop happens in the same cycle.
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter type         dtype        = logic [DATA_WIDTH-1:0],
    localparam int unsigned ADDR_DEPTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  dtype                  data_i,
    input  logic                  push_i,
    output dtype                  data_o,
    input  logic                  pop_i
);

    localparam logic [ADDR_DEPTH:0] FULL_CNT = (ADDR_DEPTH+1)'(DEPTH);

    logic [ADDR_DEPTH-1:0] rd_ptr_q, wr_ptr_q;
    logic [ADDR_DEPTH:0]   cnt_q;
    dtype                  mem_q [DEPTH];
    logic                  do_push, do_pop;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0) && !(FALL_THROUGH && push_i);
    assign usage_o = cnt_q[ADDR_DEPTH-1:0];

    always_comb begin
        data_o  = mem_q[rd_ptr_q];
        do_push = push_i && (!full_o || pop_i);
        do_pop  = pop_i && !empty_o;
        if (FALL_THROUGH && (cnt_q == '0) && push_i) begin
            data_o = data_i;
            if (pop_i) begin
                do_push = 1'b0;
                do_pop  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + ADDR_DEPTH'(1);
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + ADDR_DEPTH'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (ADDR_DEPTH+1)'(1);
                2'b01:   cnt_q <= cnt_q - (ADDR_DEPTH+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/dir_read_rsp_route.sv
// Directory read response router.
// Tracks each directory SRAM read with a tag that travels RdLatency stages,
// masks the returned entries by the read chip selects, and delivers them:
//   coherence reads -> coh_rsp_* single-cycle pulse, no backpressure
//   core reads      -> core response FIFO, valid/ready handshake
// Ports:
//   issue_*            : access presented to the SRAM this cycle
//   dir_rentry_i       : SRAM read data (valid at the tag pipeline tail)
//   coh_rsp_*          : coherence response pulse
//   core_rsp_*         : head of the core response FIFO
//   core_issue_allow_o : a core read may be issued without risking a drop
//   overflow_o         : sticky; a core response was dropped
// Way count and field widths come from the package.
module dir_read_rsp_route
    import dir_read_rsp_route_pkg::*;
#(
    parameter int unsigned RdLatency    = 1,
    parameter int unsigned RspFifoDepth = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 issue_src_i,
    input  hpdcache_dir_addr_t   issue_addr_i,
    input  hpdcache_way_vector_t issue_cs_i,
    input  hpdcache_way_vector_t issue_we_i,
    input  dir_entries_t         dir_rentry_i,
    output logic                 coh_rsp_valid_o,
    output hpdcache_dir_addr_t   coh_rsp_addr_o,
    output hpdcache_way_vector_t coh_rsp_cs_o,
    output dir_entries_t         coh_rsp_entry_o,
    output logic                 core_rsp_valid_o,
    input  logic                 core_rsp_ready_i,
    output hpdcache_dir_addr_t   core_rsp_addr_o,
    output hpdcache_way_vector_t core_rsp_cs_o,
    output dir_entries_t         core_rsp_entry_o,
    output logic                 core_issue_allow_o,
    output logic                 overflow_o
);

    localparam int unsigned PtrW = (RspFifoDepth > 1) ? $clog2(RspFifoDepth) : 1;
    localparam int unsigned UseW = PtrW + 1;
    localparam int unsigned CntW = $clog2(RdLatency + 1);
    localparam int unsigned SumW = ((UseW > CntW) ? UseW : CntW) + 1;

    dir_tag_t [RdLatency-1:0] tag_q;
    dir_tag_t                 issue_tag, tail_tag;
    logic                     issue_rd, issue_core, tail_core, tail_coh;
    logic [CntW-1:0]          inflight_core_q;
    logic                     overflow_q, drop;
    logic                     fifo_full, fifo_empty, fifo_push, core_pop;
    logic [PtrW-1:0]          fifo_usage_raw;
    logic [UseW-1:0]          fifo_usage;
    logic [SumW-1:0]          credit_used;
    dir_entries_t             tail_entry;
    dir_core_rsp_t            push_rsp, head_rsp;

    // Any write-enable bit turns the access into a write: no response.
    assign issue_rd   = (|issue_cs_i) && !(|issue_we_i);
    assign issue_tag  = '{valid: issue_rd, src: dir_src_e'(issue_src_i),
                          addr: issue_addr_i, cs: issue_cs_i};
    assign issue_core = issue_rd && (issue_tag.src == DIR_SRC_CORE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tag_q <= '0;
        end else begin
            tag_q[0] <= issue_tag;
            for (int i = 1; i < RdLatency; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    assign tail_tag   = tag_q[RdLatency-1];
    assign tail_entry = mask_entries(dir_rentry_i, tail_tag.cs);
    assign tail_coh   = tail_tag.valid && (tail_tag.src == DIR_SRC_COH);
    assign tail_core  = tail_tag.valid && (tail_tag.src == DIR_SRC_CORE);

    // Coherence path: data outputs are held at zero outside the pulse.
    assign coh_rsp_valid_o = tail_coh;
    assign coh_rsp_addr_o  = tail_coh ? tail_tag.addr : '0;
    assign coh_rsp_cs_o    = tail_coh ? tail_tag.cs   : '0;
    assign coh_rsp_entry_o = tail_coh ? tail_entry    : '0;

    // Core path.
    assign core_rsp_valid_o = !fifo_empty;
    assign core_pop         = core_rsp_valid_o && core_rsp_ready_i;
    assign fifo_push        = tail_core && (!fifo_full || core_pop);
    assign drop             = tail_core && fifo_full && !core_pop;
    assign push_rsp         = '{addr: tail_tag.addr, cs: tail_tag.cs, entry: tail_entry};

    fifo_v3 #(
        .FALL_THROUGH (1'b0),
        .DEPTH        (RspFifoDepth),
        .dtype        (dir_core_rsp_t)
    ) u_rsp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (1'b0),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .usage_o (fifo_usage_raw),
        .data_i  (push_rsp),
        .push_i  (fifo_push),
        .data_o  (head_rsp),
        .pop_i   (core_pop)
    );

    assign core_rsp_addr_o  = head_rsp.addr;
    assign core_rsp_cs_o    = head_rsp.cs;
    assign core_rsp_entry_o = head_rsp.entry;

    // fifo usage_o wraps to zero when full; rebuild the true occupancy.
    assign fifo_usage = fifo_full ? UseW'(RspFifoDepth) : {1'b0, fifo_usage_raw};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight_core_q <= '0;
        end else begin
            case ({issue_core, tail_core})
                2'b10:   inflight_core_q <= inflight_core_q + CntW'(1);
                2'b01:   inflight_core_q <= inflight_core_q - CntW'(1);
                default: inflight_core_q <= inflight_core_q;
            endcase
        end
    end

    // Credit covers both stored responses and reads still in the SRAM.
    assign credit_used        = SumW'(fifo_usage) + SumW'(inflight_core_q);
    assign core_issue_allow_o = credit_used < SumW'(RspFifoDepth);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) overflow_q <= 1'b0;
        else if (drop) overflow_q <= 1'b1;
    end

    // Flag is visible in the cycle the response is dropped, then held.
    assign overflow_o = overflow_q || drop;

endmodule

// File: tb/tb_dir_read_rsp_route.sv
module tb_dir_read_rsp_route;
    import dir_read_rsp_route_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 issue_src = 1'b0;
    hpdcache_dir_addr_t   issue_addr = '0;
    hpdcache_way_vector_t issue_cs = '0;
    hpdcache_way_vector_t issue_we = '0;
    dir_entries_t         rentry = '0;
    logic                 coh_v;
    hpdcache_dir_addr_t   coh_addr;
    hpdcache_way_vector_t coh_cs;
    dir_entries_t         coh_ent;
    logic                 core_v;
    logic                 core_rdy = 1'b0;
    hpdcache_dir_addr_t   core_addr;
    hpdcache_way_vector_t core_cs;
    dir_entries_t         core_ent;
    logic                 allow;
    logic                 ovf;

    localparam logic [63:0] R = 64'hD3D3_C2C2_B1B1_A0A0;

    always #5 clk = ~clk;

    dir_read_rsp_route #(.RdLatency(1), .RspFifoDepth(4)) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .issue_src_i        (issue_src),
        .issue_addr_i       (issue_addr),
        .issue_cs_i         (issue_cs),
        .issue_we_i         (issue_we),
        .dir_rentry_i       (rentry),
        .coh_rsp_valid_o    (coh_v),
        .coh_rsp_addr_o     (coh_addr),
        .coh_rsp_cs_o       (coh_cs),
        .coh_rsp_entry_o    (coh_ent),
        .core_rsp_valid_o   (core_v),
        .core_rsp_ready_i   (core_rdy),
        .core_rsp_addr_o    (core_addr),
        .core_rsp_cs_o      (core_cs),
        .core_rsp_entry_o   (core_ent),
        .core_issue_allow_o (allow),
        .overflow_o         (ovf)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic src, input logic [7:0] addr, input logic [3:0] cs,
                         input logic [3:0] we, input logic rdy);
        issue_src  = src;
        issue_addr = addr;
        issue_cs   = cs;
        issue_we   = we;
        core_rdy   = rdy;
    endtask

    task automatic next();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic        src;
        logic [7:0]  addr;
        logic [3:0]  cs;
        logic [3:0]  we;
        logic        rdy;
        logic        e_coh_v;
        logic [7:0]  e_coh_addr;
        logic [3:0]  e_coh_cs;
        logic [63:0] e_coh_ent;
        logic        e_core_v;
        logic [7:0]  e_core_addr;
        logic [63:0] e_core_ent;
        logic        e_allow;
    } vec_t;

    vec_t tbl[12];
    logic [7:0] coh_q[$];
    logic [7:0] core_q[$];

    initial begin
        // Inputs are applied for one cycle; expectations are the outputs in that same cycle.
        tbl[0]  = '{0, 8'h00, 4'b0000, 4'b0000, 1, 0, 8'h00, 4'b0000, 64'h0, 0, 8'h00, 64'h0, 1};
        tbl[1]  = '{1, 8'h12, 4'b0101, 4'b0000, 1, 0, 8'h00, 4'b0000, 64'h0, 0, 8'h00, 64'h0, 1};
        tbl[2]  = '{0, 8'h00, 4'b0000, 4'b0000, 1, 1, 8'h12, 4'b0101,
                    64'h0000_C2C2_0000_A0A0, 0, 8'h00, 64'h0, 1};
        tbl[3]  = '{0, 8'h03, 4'b1111, 4'b0000, 1, 0, 8'h00, 4'b0000, 64'h0, 0, 8'h00, 64'h0, 1};
        tbl[4]  = '{0, 8'h00, 4'b0000, 4'b0000, 1, 0, 8'h00, 4'b0000, 64'h0, 0, 8'h00, 64'h0, 1};
        tbl[5]  = '{0, 8'h00, 4'b0000, 4'b0000, 1, 0, 8'h00, 4'b0000, 64'h0, 1, 8'h03, R, 1};
        tbl[6]  = '{0, 8'h00, 4'b0000, 4'b0000, 1, 0, 8'h00, 4'b0000, 64'h0, 0, 8'h00, 64'h0, 1};
        tbl[7]  = '{0, 8'h05, 4'b0010, 4'b0010, 1, 0, 8'h00, 4'b0000, 64'h0, 0, 8'h00, 64'h0, 1};
        tbl[8]  = '{0, 8'h00, 4'b0000, 4'b0000, 1, 0, 8'h00, 4'b0000, 64'h0, 0, 8'h00, 64'h0, 1};
        tbl[9]  = '{1, 8'h2A, 4'b1010, 4'b0000, 1, 0, 8'h00, 4'b0000, 64'h0, 0, 8'h00, 64'h0, 1};
        tbl[10] = '{0, 8'h00, 4'b0000, 4'b0000, 1, 1, 8'h2A, 4'b1010,
                    64'hD3D3_0000_B1B1_0000, 0, 8'h00, 64'h0, 1};
        tbl[11] = '{0, 8'h00, 4'b0000, 4'b0000, 1, 0, 8'h00, 4'b0000, 64'h0, 0, 8'h00, 64'h0, 1};

        rentry = R;
        // Reset state
        @(negedge clk);
        #1;
        chk("rst_coh_v", 64'(coh_v), 64'd0);
        chk("rst_core_v", 64'(core_v), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_allow", 64'(allow), 64'd1);
        chk("rst_coh_ent", coh_ent, 64'h0);
        chk("rst_core_addr", 64'(core_addr), 64'h0);
        chk("rst_core_ent", core_ent, 64'h0);
        next();
        rst_n = 1'b1;
        next();

        // Table vectors
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].src, tbl[i].addr, tbl[i].cs, tbl[i].we, tbl[i].rdy);
            #1;
            chk($sformatf("tbl%0d_coh_v", i), 64'(coh_v), 64'(tbl[i].e_coh_v));
            chk($sformatf("tbl%0d_coh_addr", i), 64'(coh_addr), 64'(tbl[i].e_coh_addr));
            chk($sformatf("tbl%0d_coh_cs", i), 64'(coh_cs), 64'(tbl[i].e_coh_cs));
            chk($sformatf("tbl%0d_coh_ent", i), coh_ent, tbl[i].e_coh_ent);
            chk($sformatf("tbl%0d_core_v", i), 64'(core_v), 64'(tbl[i].e_core_v));
            if (tbl[i].e_core_v) begin
                chk($sformatf("tbl%0d_core_addr", i), 64'(core_addr), 64'(tbl[i].e_core_addr));
                chk($sformatf("tbl%0d_core_ent", i), core_ent, tbl[i].e_core_ent);
            end
            chk($sformatf("tbl%0d_allow", i), 64'(allow), 64'(tbl[i].e_allow));
            chk($sformatf("tbl%0d_ovf", i), 64'(ovf), 64'd0);
            if (i == 8) chk("write_inflight", 64'(dut.inflight_core_q), 64'd0);
            next();
        end

        // Credit: fill with ready low, then drain in order
        for (int i = 0; i < 4; i++) begin
            drive(0, 8'(i), 4'b1111, 4'b0000, 0);
            #1;
            chk($sformatf("credit_allow_issue%0d", i), 64'(allow), 64'd1);
            next();
        end
        drive(0, 8'h00, 4'b0000, 4'b0000, 0);
        #1;
        chk("credit_allow_after4", 64'(allow), 64'd0);
        chk("credit_head_v", 64'(core_v), 64'd1);
        next();
        #1;
        chk("credit_allow_full", 64'(allow), 64'd0);
        next();
        drive(0, 8'h00, 4'b0000, 4'b0000, 1);
        #1;
        chk("credit_pop0_addr", 64'(core_addr), 64'd0);
        chk("credit_allow_during_pop", 64'(allow), 64'd0);
        next();
        drive(0, 8'h00, 4'b0000, 4'b0000, 0);
        #1;
        chk("credit_allow_restored", 64'(allow), 64'd1);
        next();
        for (int k = 1; k < 4; k++) begin
            drive(0, 8'h00, 4'b0000, 4'b0000, 1);
            #1;
            chk($sformatf("credit_pop%0d_v", k), 64'(core_v), 64'd1);
            chk($sformatf("credit_pop%0d_addr", k), 64'(core_addr), 64'(k));
            next();
        end
        drive(0, 8'h00, 4'b0000, 4'b0000, 0);
        #1;
        chk("credit_drained", 64'(core_v), 64'd0);
        next();

        // Interleaving core/coherence with ready high
        begin
            logic ovf_seen;
            ovf_seen = 1'b0;
            for (int i = 0; i < 12; i++) begin
                if (i < 8) drive(i[0], 8'h20 + 8'(i), 4'b1111, 4'b0000, 1);
                else       drive(0, 8'h00, 4'b0000, 4'b0000, 1);
                #1;
                if (coh_v) coh_q.push_back(coh_addr);
                if (core_v) core_q.push_back(core_addr);
                ovf_seen = ovf_seen | ovf;
                next();
            end
            chk("ilv_ovf", 64'(ovf_seen), 64'd0);
            chk("ilv_coh_cnt", 64'(coh_q.size()), 64'd4);
            chk("ilv_core_cnt", 64'(core_q.size()), 64'd4);
            for (int k = 0; k < 4; k++) begin
                if (k < coh_q.size())  chk($sformatf("ilv_coh%0d", k), 64'(coh_q[k]), 64'(8'h21 + 8'(2*k)));
                if (k < core_q.size()) chk($sformatf("ilv_core%0d", k), 64'(core_q[k]), 64'(8'h20 + 8'(2*k)));
            end
        end

        // Overflow: fifth core read issued against allow=0 with ready low
        for (int i = 0; i < 4; i++) begin
            drive(0, 8'(i), 4'b1111, 4'b0000, 0);
            next();
        end
        drive(0, 8'h05, 4'b1111, 4'b0000, 0);
        #1;
        chk("ovf_allow_low", 64'(allow), 64'd0);
        chk("ovf_before", 64'(ovf), 64'd0);
        next();
        drive(0, 8'h00, 4'b0000, 4'b0000, 0);
        #1;
        chk("ovf_set", 64'(ovf), 64'd1);
        next();
        #1;
        chk("ovf_sticky", 64'(ovf), 64'd1);
        chk("ovf_head_addr", 64'(core_addr), 64'd0);
        next();
        next();
        #1;
        chk("ovf_sticky2", 64'(ovf), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_clr_ovf", 64'(ovf), 64'd0);
        chk("rst_clr_core_v", 64'(core_v), 64'd0);
        chk("rst_clr_allow", 64'(allow), 64'd1);
        next();
        rst_n = 1'b1;
        next();

        // Reset mid-flight: neither the pushed core read nor the in-flight coherence read survives
        drive(0, 8'h07, 4'b1111, 4'b0000, 0);
        next();
        drive(1, 8'h08, 4'b1111, 4'b0000, 0);
        next();
        drive(0, 8'h00, 4'b0000, 4'b0000, 0);
        rst_n = 1'b0;
        #1;
        chk("flush_coh_v", 64'(coh_v), 64'd0);
        next();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("flush_core_v%0d", i), 64'(core_v), 64'd0);
            chk($sformatf("flush_coh_v%0d", i), 64'(coh_v), 64'd0);
            next();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
